// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends only on registered state, so decode stalls never reach fetch combinationally.
module if_id_skid_reg #(
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc_plus4,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc_plus4,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  // state | meaning
  // EMPTY | no held entries
  // ONE   | main entry valid, skid free
  // FULL  | main and skid entries valid
  // Encoding is {s_valid, m_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PC_W-1:0]    r_m_pc;
  logic [INSTR_W-1:0] r_m_instr;
  logic [PC_W-1:0]    r_s_pc;
  logic [INSTR_W-1:0] r_s_instr;

  logic w_m_valid;
  logic w_s_valid;
  logic w_in_ready;
  logic w_acc;
  logic w_deq;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  assign w_m_valid  = r_state[0];
  assign w_s_valid  = r_state[1];
  assign w_in_ready = ~w_s_valid;
  assign w_acc      = in_valid & w_in_ready;
  assign w_deq      = w_m_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && w_deq) begin
          w_ld_main_in = 1'b1;
        end else if (w_acc) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_deq) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_deq) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush only kills the valid bits; any data written this cycle is never observed.
    if (flush) w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_pc    <= '0;
      r_m_instr <= NOP_INSTR;
      r_s_pc    <= '0;
      r_s_instr <= NOP_INSTR;
    end else begin
      if (w_ld_main_in) begin
        r_m_pc    <= in_pc_plus4;
        r_m_instr <= in_instr;
      end else if (w_ld_main_skid) begin
        r_m_pc    <= r_s_pc;
        r_m_instr <= r_s_instr;
      end
      if (w_ld_skid) begin
        r_s_pc    <= in_pc_plus4;
        r_s_instr <= in_instr;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_m_valid;
  assign out_pc_plus4 = r_m_pc;
  assign out_instr    = w_m_valid ? r_m_instr : NOP_INSTR;
  assign occupancy    = {1'b0, w_m_valid} + {1'b0, w_s_valid};

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and randomized checks for the IF/ID skid register.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc_plus4, out_pc_plus4;
  logic [31:0] in_instr, out_instr;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_plus4(in_pc_plus4), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [63:0] pc, input logic [31:0] ins, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_pc_plus4 = pc; in_instr = ins; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [63:0] pc,
                            input logic [31:0] ins, input logic [1:0] occ, input logic rdy);
    check_eq({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
    if (v) check_eq({tag, ".pc"}, out_pc_plus4, pc);
    check_eq({tag, ".instr"}, {32'd0, out_instr}, {32'd0, ins});
    check_eq({tag, ".occ"}, {62'd0, occupancy}, {62'd0, occ});
    check_eq({tag, ".rdy"}, {63'd0, in_ready}, {63'd0, rdy});
  endtask

  logic [95:0] q[$];
  logic        m_acc, m_deq;

  initial begin
    drive(1, 0, 0, 64'h0, NOP, 0);
    tick(); tick();
    drive(0, 0, 0, 64'h0, NOP, 0);
    check_eq("rst.pc", out_pc_plus4, 64'h0);
    expect_out("rst", 0, 64'h0, NOP, 2'd0, 1);

    // Full-throughput stream: each instr visible one cycle after acceptance.
    drive(0, 0, 1, 64'h4, 32'h00A0_0093, 1); tick();
    expect_out("s0", 1, 64'h4, 32'h00A0_0093, 2'd1, 1);
    drive(0, 0, 1, 64'h8, 32'h0010_0113, 1); tick();
    expect_out("s1", 1, 64'h8, 32'h0010_0113, 2'd1, 1);
    drive(0, 0, 1, 64'hC, 32'h0020_0193, 1); tick();
    expect_out("s2", 1, 64'hC, 32'h0020_0193, 2'd1, 1);
    drive(0, 0, 1, 64'h10, 32'h0030_0213, 1); tick();
    expect_out("s3", 1, 64'h10, 32'h0030_0213, 2'd1, 1);
    drive(0, 0, 0, 64'h0, 32'hxxxx_xxxx, 1); tick();
    expect_out("s_drain", 0, 64'h0, NOP, 2'd0, 1);
    tick();
    expect_out("xsafe", 0, 64'h0, NOP, 2'd0, 1);

    // Backpressure fills the skid; third offer must be refused.
    drive(0, 0, 1, 64'h40, 32'h11, 0); tick();
    expect_out("bp0", 1, 64'h40, 32'h11, 2'd1, 1);
    drive(0, 0, 1, 64'h44, 32'h22, 0); tick();
    expect_out("bp1", 1, 64'h40, 32'h11, 2'd2, 0);
    drive(0, 0, 1, 64'h48, 32'h33, 0); tick();
    expect_out("bp2", 1, 64'h40, 32'h11, 2'd2, 0);
    drive(0, 0, 0, 64'h0, 32'h0, 1); tick();
    expect_out("bp3", 1, 64'h44, 32'h22, 2'd1, 1);
    tick();
    expect_out("bp4", 0, 64'h0, NOP, 2'd0, 1);

    // Flush from FULL.
    drive(0, 0, 1, 64'h60, 32'h61, 0); tick();
    drive(0, 0, 1, 64'h64, 32'h65, 0); tick();
    expect_out("fl_full_pre", 1, 64'h60, 32'h61, 2'd2, 0);
    drive(0, 1, 0, 64'h0, 32'h0, 0); tick();
    expect_out("fl_full", 0, 64'h0, NOP, 2'd0, 1);

    // Flush from ONE discards the same-cycle accepted input.
    drive(0, 0, 1, 64'h50, 32'h51, 0); tick();
    expect_out("fl_one_pre", 1, 64'h50, 32'h51, 2'd1, 1);
    drive(0, 1, 1, 64'h20, 32'h21, 0); tick();
    expect_out("fl_one", 0, 64'h0, NOP, 2'd0, 1);
    drive(0, 0, 0, 64'h0, 32'h0, 1); tick();
    expect_out("fl_one_post", 0, 64'h0, NOP, 2'd0, 1);

    // Reset while FULL, with flush and in_valid also asserted.
    drive(0, 0, 1, 64'h70, 32'h71, 0); tick();
    drive(0, 0, 1, 64'h74, 32'h75, 0); tick();
    expect_out("rst_full_pre", 1, 64'h70, 32'h71, 2'd2, 0);
    drive(1, 1, 1, 64'h78, 32'h79, 0); tick();
    check_eq("rst_full.pc", out_pc_plus4, 64'h0);
    expect_out("rst_full", 0, 64'h0, NOP, 2'd0, 1);
    drive(0, 0, 0, 64'h0, 32'h0, 0); tick();
    expect_out("rst_full_post", 0, 64'h0, NOP, 2'd0, 1);

    // Random traffic against a FIFO scoreboard.
    q.delete();
    for (int c = 0; c < 4000; c++) begin
      drive(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            {$urandom, $urandom}, $urandom, $urandom_range(0, 1) == 1);
      #1;
      check_eq("rnd.rdy", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
      m_acc = in_valid && (q.size() < 2);
      m_deq = out_ready && (q.size() > 0);
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (m_deq) void'(q.pop_front());
        if (m_acc) q.push_back({in_pc_plus4, in_instr});
      end
      #1;
      check_eq("rnd.valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
      check_eq("rnd.occ", {62'd0, occupancy}, 64'(q.size()));
      if (q.size() > 0) begin
        check_eq("rnd.pc", out_pc_plus4, q[0][95:32]);
        check_eq("rnd.instr", {32'd0, out_instr}, {32'd0, q[0][31:0]});
      end else begin
        check_eq("rnd.nop", {32'd0, out_instr}, {32'd0, NOP});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
